// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with carry-in, carry-out, signed overflow and optional
// unsigned saturation. Each stage adds one CHUNK-bit slice; the carry ripples between
// stages through registers. Valid/ready on both sides, with the whole pipe stalling together.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned LAST  = STAGES - 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES");
  end

  // Per-stage pipe registers. r_a keeps the original A (its MSB feeds the overflow flag),
  // r_b keeps B after optional inversion, r_s accumulates the result slices added so far.
  logic             r_v  [STAGES];
  logic [WIDTH-1:0] r_a  [STAGES];
  logic [WIDTH-1:0] r_b  [STAGES];
  logic [WIDTH-1:0] r_s  [STAGES];
  logic             r_c  [STAGES];
  logic [1:0]       r_op [STAGES];

  // Stage inputs (operands entering stage k) and stage results.
  logic             w_v_in  [STAGES];
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic [1:0]       w_op_in [STAGES];
  logic [CHUNK:0]   w_add   [STAGES];
  logic [WIDTH-1:0] w_s_nx  [STAGES];
  logic             w_c_nx  [STAGES];

  logic             w_adv;
  logic             w_sub;
  logic [WIDTH-1:0] w_r;
  logic             w_c;

  assign w_sub    = op[0];
  assign w_adv    = ~r_v[LAST] | out_ready;
  assign in_ready = w_adv;

  // Per-stage slice addition: stage k adds bits [k*CHUNK +: CHUNK] with the carry from k-1.
  always_comb begin
    w_v_in[0]  = in_valid;
    w_a_in[0]  = a;
    w_b_in[0]  = w_sub ? ~b : b;
    w_c_in[0]  = w_sub ? ~cin : cin;
    w_s_in[0]  = '0;
    w_op_in[0] = op;
    for (int k = 1; k < STAGES; k++) begin
      w_v_in[k]  = r_v[k-1];
      w_a_in[k]  = r_a[k-1];
      w_b_in[k]  = r_b[k-1];
      w_c_in[k]  = r_c[k-1];
      w_s_in[k]  = r_s[k-1];
      w_op_in[k] = r_op[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_add[k]  = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]} + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, w_c_in[k]};
      w_s_nx[k] = w_s_in[k];
      w_s_nx[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
      w_c_nx[k] = w_add[k][CHUNK];
    end
  end

  // Pipe shift: every stage moves together when the output side can advance, else all hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]  <= 1'b0;
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_s[k]  <= '0;
        r_c[k]  <= 1'b0;
        r_op[k] <= 2'b00;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]  <= w_v_in[k];
        r_a[k]  <= w_a_in[k];
        r_b[k]  <= w_b_in[k];
        r_s[k]  <= w_s_nx[k];
        r_c[k]  <= w_c_nx[k];
        r_op[k] <= w_op_in[k];
      end
    end
  end

  assign w_r = r_s[LAST];
  assign w_c = r_c[LAST];

  // Output decode from the last stage; flags are taken from the raw, unsaturated result.
  always_comb begin
    out_valid = r_v[LAST];
    cout      = w_c;
    ovf       = (r_a[LAST][MSB] == r_b[LAST][MSB]) && (w_r[MSB] != r_a[LAST][MSB]);
    case (r_op[LAST])
      2'b10:   sum = w_c ? '1 : w_r;   // unsigned add overflow clamps high
      2'b11:   sum = w_c ? w_r : '0;   // carry clear means borrow: clamp low
      default: sum = w_r;
    endcase
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: scoreboard with a plain-arithmetic reference model, random and
// directed beats, stalls, bubbles, asynchronous reset, plus a 1-bit/1-stage half-adder instance.
module tb_pipelined_adder;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
    int           st;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [W-1:0] a, b, sum;
  logic [1:0]   op;

  logic         h_in_valid, h_in_ready, h_out_valid, h_cout, h_ovf, h_cin;
  logic [0:0]   h_a, h_b, h_sum;
  logic [1:0]   h_op;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stalls = 0;
  int   last_acc = 0;
  exp_t sb[$];
  logic vhist[int];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(1), .STAGES(1)) u_ha (
    .clk(clk), .rstn(rstn), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .cin(h_cin), .op(h_op), .out_valid(h_out_valid), .out_ready(1'b1), .sum(h_sum),
    .cout(h_cout), .ovf(h_ovf)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.acc = 0; e.st = 0;
    return e;
  endfunction

  // Reference: true integer add/subtract, then wrap, flag and clamp.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic [1:0] mop);
    int   ia, ib, ic, sa, sbv, full, sres;
    logic carry;
    logic [W-1:0] r;
    ia = int'(ma); ib = int'(mb); ic = int'(mc);
    sa = int'($signed(ma)); sbv = int'($signed(mb));
    if (mop[0]) begin
      full  = ia - ib - ic;
      sres  = sa - sbv - ic;
      carry = (full >= 0);
    end else begin
      full  = ia + ib + ic;
      sres  = sa + sbv + ic;
      carry = (full > 255);
    end
    r = full[W-1:0];
    if (mop == 2'b10 && carry)  r = 8'hFF;
    if (mop == 2'b11 && !carry) r = 8'h00;
    return mk(r, carry, (sres > 127) || (sres < -128));
  endfunction

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [1:0] top, input exp_t e);
    bit ok;
    ok = 0;
    a = ta; b = tb_; cin = tc; op = top; in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept timeout: got in_ready 0 expected 1 within 100 cycles");
    end else begin
      e.acc = cyc + 1;
      e.st  = stalls;
      sb.push_back(e);
      last_acc = cyc + 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand();
    logic [W-1:0] ra, rb;
    logic rc;
    logic [1:0] rop;
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rop = 2'($urandom);
    issue(ra, rb, rc, rop, model(ra, rb, rc, rop));
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Edge counter: value at a falling edge equals the number of rising edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: pops and compares on every output handshake, checks hold during stalls.
  initial begin
    logic stall_pend, pc, po;
    logic [W-1:0] ps;
    exp_t e;
    stall_pend = 0; pc = 0; po = 0; ps = '0;
    forever begin
      @(negedge clk);
      vhist[cyc] = out_valid;
      if (!rstn) stall_pend = 0;
      else begin
        if (stall_pend) chk("held outputs", {21'd0, out_valid, cout, ovf, sum}, {21'd0, 1'b1, pc, po, ps});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected output: got sum 0x%0h expected none", sum);
          end else begin
            e = sb.pop_front();
            chk("result", {22'd0, cout, ovf, sum}, {22'd0, e.c, e.o, e.s});
            chk("latency", 32'(cyc), 32'(e.acc + int'(S) - 1 + (stalls - e.st)));
          end
        end
        stall_pend = out_valid && !out_ready;
        ps = sum; pc = cout; po = ovf;
        if (stall_pend) stalls++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [1:0] hs;
    in_valid = 0; a = '0; b = '0; cin = 0; op = 2'b00; out_ready = 1;
    h_in_valid = 0; h_a = '0; h_b = '0; h_cin = 0; h_op = 2'b00;

    #1;
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset sum", {24'd0, sum}, 0);
    chk("reset cout", {31'd0, cout}, 0);
    chk("reset ovf", {31'd0, ovf}, 0);
    chk("reset in_ready", {31'd0, in_ready}, 1);
    repeat (3) @(posedge clk);
    #3 rstn = 1;
    @(posedge clk); #1;

    // Directed vectors with hand-derived expectations.
    issue(8'hFF, 8'h01, 1'b0, 2'b00, mk(8'h00, 1'b1, 1'b0));
    issue(8'h7F, 8'h01, 1'b0, 2'b00, mk(8'h80, 1'b0, 1'b1));
    issue(8'h05, 8'h07, 1'b0, 2'b01, mk(8'hFE, 1'b0, 1'b0));
    issue(8'h05, 8'h07, 1'b0, 2'b11, mk(8'h00, 1'b0, 1'b0));
    issue(8'hF0, 8'h20, 1'b0, 2'b10, mk(8'hFF, 1'b1, 1'b0));
    issue(8'h7F, 8'h00, 1'b1, 2'b00, mk(8'h80, 1'b0, 1'b1));
    issue(8'h80, 8'h00, 1'b1, 2'b01, mk(8'h7F, 1'b1, 1'b1));
    issue(8'h10, 8'h10, 1'b1, 2'b11, mk(8'h00, 1'b0, 1'b0));
    issue(8'hFF, 8'h00, 1'b1, 2'b10, mk(8'hFF, 1'b1, 1'b0));
    drain();

    // Bubble: valid pattern 1,0,1 must reappear at the output STAGES-1 edges later.
    issue_rand();
    e0 = last_acc;
    @(posedge clk); #1;
    issue_rand();
    drain();
    chk("bubble v0", {31'd0, vhist[e0 + int'(S) - 1]}, 1);
    chk("bubble v1", {31'd0, vhist[e0 + int'(S)]}, 0);
    chk("bubble v2", {31'd0, vhist[e0 + int'(S) + 1]}, 1);

    // 16 back-to-back beats with a 3-cycle output stall in the middle.
    fork
      repeat (16) issue_rand();
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("in_ready during stall", {31'd0, in_ready}, 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // Random gaps on input, random backpressure on output.
    fork
      repeat (40) begin
        issue_rand();
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
      begin
        repeat (100) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    out_ready = 1;
    drain();

    // Asynchronous reset mid-cycle with two beats in flight.
    issue(8'h11, 8'h22, 1'b0, 2'b00, mk(8'h33, 1'b0, 1'b0));
    issue(8'h33, 8'h44, 1'b0, 2'b00, mk(8'h77, 1'b0, 1'b0));
    #2;
    chk("valid before reset", {31'd0, out_valid}, 1);
    rstn = 0;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 0);
    chk("async reset sum", {24'd0, sum}, 0);
    chk("async reset cout", {31'd0, cout}, 0);
    chk("async reset ovf", {31'd0, ovf}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("in_ready after reset", {31'd0, in_ready}, 1);
    issue(8'h01, 8'h02, 1'b0, 2'b00, mk(8'h03, 1'b0, 1'b0));
    drain();

    // Degenerate 1-bit, 1-stage instance behaves as a registered half adder.
    for (int i = 0; i < 4; i++) begin
      h_a = 1'(i >> 1); h_b = 1'(i);
      hs = {1'b0, h_a} + {1'b0, h_b};
      h_in_valid = 1;
      chk("ha in_ready", {31'd0, h_in_ready}, 1);
      @(posedge clk); #1;
      chk("ha valid", {31'd0, h_out_valid}, 1);
      chk("ha sum", {31'd0, h_sum}, {31'd0, hs[0]});
      chk("ha cout", {31'd0, h_cout}, {31'd0, hs[1]});
      chk("ha ovf", {31'd0, h_ovf}, {31'd0, hs[1]});
    end
    h_in_valid = 0;
    @(posedge clk); #1;
    chk("ha idle", {31'd0, h_out_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
